// File: rtl/pipeline_hazard_controller.sv
// Stall / bubble / flush sequencing for the five-stage pipeline.
// Covers the hazards the EX forwarding unit cannot hide (load-use and
// ID-resolved branches waiting on operands). It applies a global freeze while
// memory is busy and keeps saturating stall and flush cycle counters.
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RegisterRs,
  input  logic [4:0]       ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic             ID_IsBranch,
  input  logic             BranchTaken,
  input  logic             ID_ExMemRead,
  input  logic             ID_ExRegWrite,
  input  logic [4:0]       ID_ExRegisterRd,
  input  logic             Ex_MemMemRead,
  input  logic [4:0]       Ex_MemRegisterRd,
  input  logic             MemBusy,
  input  logic             PerfClear,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             ID_ExBubble,
  output logic             IF_IDFlush,
  output logic             PipeFreeze,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             DebugHold     // 1 while the FSM sits in HOLD1
);

  typedef enum logic {RUN = 1'b0, HOLD1 = 1'b1} stateT;

  localparam logic [CNT_W-1:0] CntMax = '1;

  stateT state;

  logic exMatch;
  logic memMatch;
  logic hazH2;
  logic hazH1;
  logic stallCycle;
  logic freeze;
  logic flushCycle;

  // A producer register matches if it is non-zero and feeds a source of ID.
  function automatic logic matchReg(input logic [4:0] r,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       usesRt);
    return (r != 5'd0) && ((r == rs) || (usesRt && (r == rt)));
  endfunction

  assign exMatch  = matchReg(ID_ExRegisterRd, ID_RegisterRs, ID_RegisterRt, ID_UsesRt);
  assign memMatch = matchReg(Ex_MemRegisterRd, ID_RegisterRs, ID_RegisterRt, ID_UsesRt);

  // Branch on a load still in EX needs two cycles; everything else needs one
  // and is simply re-evaluated on the following cycle.
  assign hazH2 = ID_IsBranch && ID_ExMemRead && exMatch;
  assign hazH1 = (ID_ExMemRead && exMatch)
               || (ID_IsBranch && ID_ExRegWrite && !ID_ExMemRead && exMatch)
               || (ID_IsBranch && Ex_MemMemRead && memMatch);

  assign freeze     = MemBusy;
  assign stallCycle = (state == HOLD1) || hazH2 || hazH1;
  // A stalled branch is not acted on; its outcome is re-sampled once ID moves.
  assign flushCycle = !freeze && !stallCycle && ID_IsBranch && BranchTaken;

  // Control outputs: reset forces a bubble, freeze overrides stall and flush.
  always_comb begin
    PCWrite     = 1'b0;
    IF_IDWrite  = 1'b0;
    ID_ExBubble = 1'b1;
    IF_IDFlush  = 1'b0;
    PipeFreeze  = 1'b0;
    if (rst_n) begin
      PipeFreeze  = freeze;
      PCWrite     = !freeze && !stallCycle;
      IF_IDWrite  = !freeze && !stallCycle;
      ID_ExBubble = !freeze && stallCycle;
      IF_IDFlush  = flushCycle;
    end
  end

  assign DebugHold = (state == HOLD1);

  // State register and saturating performance counters; both hold during freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!freeze) begin
        case (state)
          RUN:     state <= hazH2 ? HOLD1 : RUN;
          HOLD1:   state <= RUN;
          default: state <= RUN;
        endcase
      end
      if (PerfClear) begin
        StallCount <= '0;
        FlushCount <= '0;
      end else begin
        if (!freeze && stallCycle && (StallCount != CntMax))
          StallCount <= StallCount + 1'b1;
        if (flushCycle && (FlushCount != CntMax))
          FlushCount <= FlushCount + 1'b1;
      end
    end
  end

endmodule
